// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - UART-style frame receiver for a strobed serial bit stream
//
// Frame: start(0) | NBITS_DATA data bits LSB first | even parity | stop(1)
// Ports:
//   clk_2        system clock, all state changes on posedge
//   reset        asynchronous active-low clear
//   bit_in       serial data bit
//   bit_valid    bit_in carries a new bit this cycle
//   data_out     last received word (LSB = first data bit)
//   data_valid   one-cycle pulse when data_out updates
//   parity_err   sticky: last completed frame had bad parity
//   frame_err    sticky: last frame had a 0 stop bit
//   frame_count  count of good frames, wraps
//   busy         receiver is inside a frame

module serial_frame_rx #(
  parameter int NBITS_DATA = 8,
  parameter int NBITS_CNT  = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [NBITS_DATA-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic [NBITS_CNT-1:0]  frame_count,
  output logic                  busy
);

  localparam int IDXW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBITS_DATA - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [NBITS_DATA-1:0] shift_buf, shift_buf_nxt;
  logic [IDXW-1:0]       idx, idx_nxt;
  logic                  perr, perr_nxt;
  logic [NBITS_DATA-1:0] data_out_nxt;
  logic                  data_valid_nxt;
  logic                  parity_err_nxt;
  logic                  frame_err_nxt;
  logic [NBITS_CNT-1:0]  frame_count_nxt;
  logic                  busy_nxt;

  // State register
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; nothing moves without a bit strobe
  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      case (state)
        IDLE:    if (!bit_in) state_nxt = DATA;
        DATA:    if (idx == IDX_LAST) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    shift_buf_nxt   = shift_buf;
    idx_nxt         = idx;
    perr_nxt        = perr;
    data_out_nxt    = data_out;
    data_valid_nxt  = 1'b0;
    parity_err_nxt  = parity_err;
    frame_err_nxt   = frame_err;
    frame_count_nxt = frame_count;
    busy_nxt        = (state_nxt != IDLE);
    if (bit_valid) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            // Error flags describe the frame in progress, so a new start clears them
            idx_nxt        = '0;
            parity_err_nxt = 1'b0;
            frame_err_nxt  = 1'b0;
          end
        end
        DATA: begin
          shift_buf_nxt[idx] = bit_in;
          idx_nxt            = idx + IDXW'(1);
        end
        PARITY: begin
          // Even parity: nonzero XOR over data and parity bit is a mismatch
          perr_nxt = (^shift_buf) ^ bit_in;
        end
        STOP: begin
          if (bit_in) begin
            // Word is delivered even with bad parity; only good frames are counted
            data_out_nxt   = shift_buf;
            data_valid_nxt = 1'b1;
            parity_err_nxt = perr;
            if (!perr) frame_count_nxt = frame_count + NBITS_CNT'(1);
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      shift_buf   <= '0;
      idx         <= '0;
      perr        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      shift_buf   <= shift_buf_nxt;
      idx         <= idx_nxt;
      perr        <= perr_nxt;
      data_out    <= data_out_nxt;
      data_valid  <= data_valid_nxt;
      parity_err  <= parity_err_nxt;
      frame_err   <= frame_err_nxt;
      frame_count <= frame_count_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed table-driven bench for serial_frame_rx

module tb_serial_frame_rx;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       bit_in = 1'b1;
  logic       bit_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] frame_count;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int dv_pulses = 0;

  serial_frame_rx #(.NBITS_DATA(8), .NBITS_CNT(8)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk_2 = ~clk_2;

  // data_valid is high for a full period, so one negedge sample per pulse
  always @(negedge clk_2) if (data_valid === 1'b1) dv_pulses++;

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic       stop;
    int         gap;
    int         idle_ones;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk_2);
      bit_valid = 1'b0;
      bit_in    = ~bit_in;
    end
    @(negedge clk_2);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  // Returns just after the posedge that samples the stop bit
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop,
                            input int gap, input int idle_ones, input bit chk_start);
    int g;
    for (int i = 0; i < idle_ones; i++) send_bit(1'b1, 0);
    g = gap ? $urandom_range(1, 3) : 0;
    send_bit(1'b0, g);
    if (chk_start) begin
      @(posedge clk_2); #1;
      chk("start_busy", busy, 1);
      chk("start_perr_clr", parity_err, 0);
      chk("start_ferr_clr", frame_err, 0);
    end
    for (int i = 0; i < 8; i++) begin
      g = gap ? $urandom_range(1, 3) : 0;
      send_bit(d[i], g);
    end
    g = gap ? $urandom_range(1, 3) : 0;
    send_bit((^d) ^ par_bad, g);
    g = gap ? $urandom_range(1, 3) : 0;
    send_bit(stop, g);
    @(posedge clk_2); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    //          data   pbad  stop gap idle  exp_data valid perr ferr cnt
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 0,    8'hA5,   1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 0, 2,    8'h3C,   1'b1, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 0, 0,    8'h3C,   1'b0, 1'b0, 1'b1, 8'd1};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1, 3,    8'hA5,   1'b1, 1'b0, 1'b0, 8'd2};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 0, 0,    8'h01,   1'b1, 1'b0, 1'b0, 8'd3};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 1,    8'hFF,   1'b1, 1'b0, 1'b0, 8'd4};

    #12;
    chk_all_zero("reset");
    @(negedge clk_2);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      // Frame after the parity-error frame checks that its start bit clears the flag
      send_frame(vecs[v].data, vecs[v].par_bad, vecs[v].stop,
                 vecs[v].gap, vecs[v].idle_ones, (v == 2));
      chk($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_data);
      chk($sformatf("v%0d_data_valid", v), data_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d_parity_err", v), parity_err, vecs[v].exp_perr);
      chk($sformatf("v%0d_frame_err", v), frame_err, vecs[v].exp_ferr);
      chk($sformatf("v%0d_frame_count", v), frame_count, vecs[v].exp_cnt);
      chk($sformatf("v%0d_busy", v), busy, 0);
      @(negedge clk_2);
      bit_valid = 1'b0;
      @(posedge clk_2); #1;
      chk($sformatf("v%0d_valid_drop", v), data_valid, 0);
      chk($sformatf("v%0d_data_hold", v), data_out, vecs[v].exp_data);
    end
    chk("pulses_table", dv_pulses, 5);

    // Async reset after four data bits
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    @(posedge clk_2); #3;
    chk("midframe_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk_2);
    bit_valid = 1'b0;
    @(negedge clk_2);
    reset = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("r81_data_out", data_out, 8'h81);
    chk("r81_data_valid", data_valid, 1);
    chk("r81_count", frame_count, 1);
    chk("r81_perr", parity_err, 0);

    // Count wrap with stop followed immediately by the next start bit
    @(negedge clk_2);
    bit_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk_2);
    reset = 1'b1;
    dv_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 0, 0, 1'b0);
      if (i == 254) chk("wrap_count_255", frame_count, 8'd255);
    end
    chk("wrap_count_0", frame_count, 8'd0);
    chk("wrap_last_data", data_out, 8'hFF);
    @(negedge clk_2);
    bit_valid = 1'b0;
    @(posedge clk_2); #1;
    chk("wrap_pulses", dv_pulses, 256);
    chk("wrap_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
